apb_gpio_periph: RTL and testbench
==================================

Name: apb_gpio_periph

Overview:
- Parametrised APB3 general-purpose I/O peripheral. It is the successor of the 8-bit output-only GPO.
- Width-generic and bidirectional. Per-pin direction and output data; synchronised input readback.
- Per-pin edge-triggered interrupts with write-1-to-clear status and a level IRQ output.
- Sits on the APB bus behind the master's decoder. Pad tristating is done at chip top from gpio_o/gpio_oe.

Parameters:
- WIDTH, 8, number of GPIO pins, legal 1..16.
- SYNC_STAGES, 2, input synchroniser depth, legal 2..3.

Ports:
- PCLK  input  1  APB clock, sole clock.
- PRESETn  input  1  asynchronous, active-low reset.
- PADDR  input  5  byte address; PADDR[4:2] selects register.
- PWDATA  input  32  write data.
- PWRITE  input  1  1=write.
- PENABLE  input  1  APB access phase.
- PSEL  input  1  slave select.
- PRDATA  output  32  read data, valid while PREADY=1.
- PREADY  output  1  transfer complete.
- PSLVERR  output  1  unmapped-address error, valid while PREADY=1.
- gpio_i  input  WIDTH  asynchronous pad inputs.
- gpio_o  output  WIDTH  output data (= ODR).
- gpio_oe  output  WIDTH  output enable (= MODE), 1=drive.
- irq  output  1  level interrupt.

Behaviour:
- Reset: all registers, synchroniser flops, PRDATA, PREADY, PSLVERR and irq are 0. Reset asserted mid-transfer aborts it; no register is modified.
- Register map; bits above WIDTH read 0 and ignore writes.
  - 0x00 MODE RW
  - 0x04 ODR RW
  - 0x08 IDR RO (synchronised pins; writes ignored, no error)
  - 0x0C IER RW
  - 0x10 EDGE RW (1=rising, 0=falling)
  - 0x14 ISR RW1C
  - 0x18 BSRR WO (optional feature; see below)
  - 0x1C and disabled BSRR are unmapped.
- APB handshake: exactly one wait state.
  - Edge 1: first PCLK edge with PSEL&&PENABLE&&!PREADY. PREADY<=1; write takes effect on this edge; PRDATA is latched on this edge.
  - Edge 2: next edge. PREADY<=0 unconditionally.
  - Transfer length is setup + 2 access cycles. Back-to-back transfers never see stale PREADY.
- Unmapped address: PSLVERR=1 alongside PREADY, write ignored, PRDATA=0. PSLVERR clears with PREADY.
- PRDATA holds its last value when idle.
- Input path: gpio_i passes through SYNC_STAGES flops to sync, plus one prev register. Edge condition per pin: rise = sync&~prev, fall = ~sync&prev.
- ISR[i] set condition: IER[i] && (EDGE[i] ? rise : fall). With SYNC_STAGES=2, the ISR bit is set on the 3rd PCLK edge after the pin change is first sampled.
- No false edges after reset: IER resets to 0, so no pending bit can arise until software enables the pin.
- ISR clear: writing 1 clears a bit; writing 0 has no effect. A set and a clear on the same edge resolve to set.
- irq: registered |(ISR&IER), one edge after ISR updates. Clearing IER[i] masks a pending bit without clearing it.
- gpio_o/gpio_oe are driven directly from registers: zero latency after the write edge.

Optional Feature:
- Macro: GPIO_BSRR_EN.
- Defined: 0x18 BSRR is write-only.
  - PWDATA[WIDTH-1:0] set ODR bits; PWDATA[16+WIDTH-1:16] clear ODR bits.
  - Set wins when both are 1 for a bit.
  - Reads return 0 with PSLVERR=0.
- Undefined: 0x18 is unmapped; an access gives PSLVERR=1.

Decomposition:
- Package apb_gpio_pkg holds:
  - register offset localparams (MODE_OFS..BSRR_OFS);
  - typedef enum for the handshake state (IDLE, DONE);
  - the max-width constant 16.
- One natural sub-module, gpio_sync_edge (WIDTH, SYNC_STAGES): synchroniser, prev register and rise/fall outputs.
- The register file and APB FSM stay in the top module.

Test Plan:
- Reset and handshake:
  - Stimulus: hold PRESETn=0, then write MODE=0xFF and ODR=0xA5.
  - Response: outputs are 0 during reset. After the writes, gpio_oe=0xFF and gpio_o=0xA5. Each write has PREADY high exactly 1 cycle, on the 2nd access cycle.
- Input readback:
  - Stimulus: gpio_i=0x3C, wait 3 cycles, read 0x08.
  - Response: PRDATA=0x0000003C, PSLVERR=0.
- Edge interrupt with W1C:
  - Stimulus: IER=0x01, EDGE=0x01; toggle gpio_i[0] 0→1.
  - Response: ISR=0x01 three edges after sampling, irq=1 one edge later. Write ISR=0x01 → ISR=0, irq=0.
- Falling edge, masked pin and set-over-clear:
  - Stimulus: IER=0x02, EDGE=0x00. Falling edges arrive on pins 1 and 2. Then a new pin-1 fall lands on the same edge as an ISR=0x02 write.
  - Response: ISR=0x02; pin 2 is not recorded. After the collision, ISR bit1 remains 1.
- Unmapped access:
  - Stimulus: write 0x1C=0xFFFFFFFF, then read 0x1C.
  - Response: PSLVERR=1 both times, PRDATA=0, no register changed.
- BSRR (with GPIO_BSRR_EN):
  - Stimulus: ODR=0x0F, then write BSRR=0x00030030.
  - Response: ODR=0x3C.
  - Stimulus: write BSRR=0x00010001.
  - Response: bit0 ends 1 (set wins). Without the macro, the same access gives PSLVERR=1.

Source files
------------

// File: rtl/apb_gpio_pkg.sv
// apb_gpio_pkg: register offsets, APB handshake states and pin-count limit for apb_gpio_periph
package apb_gpio_pkg;
  localparam logic [4:0] MODE_OFS = 5'h00;
  localparam logic [4:0] ODR_OFS  = 5'h04;
  localparam logic [4:0] IDR_OFS  = 5'h08;
  localparam logic [4:0] IER_OFS  = 5'h0C;
  localparam logic [4:0] EDGE_OFS = 5'h10;
  localparam logic [4:0] ISR_OFS  = 5'h14;
  localparam logic [4:0] BSRR_OFS = 5'h18;
  localparam int GPIO_MAX_W = 16;
  typedef enum logic {IDLE, DONE} apb_state_e;
endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: multi-flop input synchroniser with previous-value register and edge outputs
//   clk_i/rst_ni : clock, async active-low reset
//   pin_i        : asynchronous pad inputs
//   sync_o       : synchronised pin values
//   rise_o/fall_o: per-pin single-cycle edge strobes (sync vs prev)
module gpio_sync_edge
  import apb_gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;
endmodule

// File: rtl/apb_gpio_periph.sv
// apb_gpio_periph: APB3 bidirectional GPIO with synchronised readback and edge interrupts
//   PCLK/PRESETn            : APB clock, async active-low reset
//   PADDR/PWDATA/PWRITE/
//   PSEL/PENABLE            : APB request (PADDR[4:2] selects register)
//   PRDATA/PREADY/PSLVERR   : APB response, one wait state per transfer
//   gpio_i                  : asynchronous pad inputs
//   gpio_o/gpio_oe          : output data and per-pin drive enable
//   irq                     : level interrupt, |(ISR & IER)
//   Define GPIO_BSRR_EN to map the write-only set/reset register at 0x18.
module apb_gpio_periph
  import apb_gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [4:0]       PADDR,
  input  logic [31:0]      PWDATA,
  input  logic             PWRITE,
  input  logic             PENABLE,
  input  logic             PSEL,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  apb_state_e state_q, state_d;
  logic [WIDTH-1:0] mode_q, mode_d, odr_q, odr_d, ier_q, ier_d, edge_q, edge_d, isr_q, isr_d;
  logic [WIDTH-1:0] sync, rise, fall, wd, rd;
  logic [31:0] prdata_q, prdata_d;
  logic pslverr_q, pslverr_d, irq_q, irq_d, access, err, wr;
  logic [4:0] addr;
  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA};
  gpio_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i (PCLK),
    .rst_ni(PRESETn),
    .pin_i (gpio_i),
    .sync_o(sync),
    .rise_o(rise),
    .fall_o(fall)
  );
  assign addr   = {PADDR[4:2], 2'b00};
  assign wd     = PWDATA[WIDTH-1:0];
  // PREADY is low in IDLE, so this fires once per transfer on its first access edge
  assign access = PSEL && PENABLE && state_q == IDLE;
`ifdef GPIO_BSRR_EN
  assign err = addr > BSRR_OFS;
`else
  assign err = addr >= BSRR_OFS;
`endif
  assign wr = access && PWRITE && !err;
  assign rd = addr == MODE_OFS ? mode_q :
              addr == ODR_OFS  ? odr_q  :
              addr == IDR_OFS  ? sync   :
              addr == IER_OFS  ? ier_q  :
              addr == EDGE_OFS ? edge_q :
              addr == ISR_OFS  ? isr_q  : '0;
  always_comb begin
    state_d   = access ? DONE : IDLE;
    mode_d    = wr && addr == MODE_OFS ? wd : mode_q;
    odr_d     = wr && addr == ODR_OFS  ? wd : odr_q;
`ifdef GPIO_BSRR_EN
    odr_d     = wr && addr == BSRR_OFS ? (odr_q & ~PWDATA[GPIO_MAX_W +: WIDTH]) | wd : odr_d;
`endif
    ier_d     = wr && addr == IER_OFS  ? wd : ier_q;
    edge_d    = wr && addr == EDGE_OFS ? wd : edge_q;
    // new edges are OR'd in after the W1C mask so a colliding set survives
    isr_d     = (isr_q & ~(wr && addr == ISR_OFS ? wd : '0)) |
                (ier_q & ((edge_q & rise) | (~edge_q & fall)));
    irq_d     = |(isr_q & ier_q);
    pslverr_d = access && err;
    prdata_d  = access && (err || !PWRITE) ? (err ? '0 : 32'(rd)) : prdata_q;
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      odr_q     <= '0;
      ier_q     <= '0;
      edge_q    <= '0;
      isr_q     <= '0;
      irq_q     <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      odr_q     <= odr_d;
      ier_q     <= ier_d;
      edge_q    <= edge_d;
      isr_q     <= isr_d;
      irq_q     <= irq_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end
  assign PREADY  = state_q == DONE;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;
  assign gpio_o  = odr_q;
  assign gpio_oe = mode_q;
  assign irq     = irq_q;
endmodule

// File: tb/tb_apb_gpio_periph.sv
// tb_apb_gpio_periph: directed plus randomized bench against a per-cycle register-map model
module tb_apb_gpio_periph;
  localparam int W = 8;
  localparam int S = 2;
  localparam logic [31:0] M = (32'd1 << W) - 1;
`ifdef GPIO_BSRR_EN
  localparam bit BSRR = 1'b1;
`else
  localparam bit BSRR = 1'b0;
`endif
  logic PCLK = 1'b0, PRESETn = 1'b0, PWRITE = 1'b0, PENABLE = 1'b0, PSEL = 1'b0;
  logic [4:0] PADDR = '0;
  logic [31:0] PWDATA = '0, PRDATA;
  logic PREADY, PSLVERR, irq;
  logic [W-1:0] gpio_i = '0, gpio_o, gpio_oe;
  int n_vec = 0, n_err = 0;
  logic [31:0] rf [0:5];
  logic [W-1:0] h [0:S];
  logic m_rdy, m_err, m_irq, m_rd;
  logic [31:0] m_rdata;
  logic [31:0] rd;
  logic er;
  apb_gpio_periph #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );
  always #5 PCLK = ~PCLK;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
    end
  endtask
  // register map as an array indexed by PADDR[4:2]; rf[2] (IDR) comes from the pin delay line
  always @(posedge PCLK or negedge PRESETn) begin : model
    logic [31:0] sy, pv, set_m, clr_m, ier_o, edg_o, isr_o, wd;
    int ix;
    if (!PRESETn) begin
      for (int k = 0; k < 6; k++) rf[k] = '0;
      for (int k = 0; k <= S; k++) h[k] = '0;
      m_rdy = 0; m_err = 0; m_irq = 0; m_rd = 0; m_rdata = '0;
    end else begin
      sy = 32'(h[S-1]);
      pv = 32'(h[S]);
      ier_o = rf[3]; edg_o = rf[4]; isr_o = rf[5]; clr_m = '0;
      set_m = ier_o & ((edg_o & sy & ~pv) | (~edg_o & ~sy & pv));
      m_irq = |(isr_o & ier_o);
      if (PSEL && PENABLE && !m_rdy) begin
        ix = int'(PADDR[4:2]);
        wd = PWDATA & M;
        m_rdy = 1; m_rd = !PWRITE;
        m_err = ix == 7 || (ix == 6 && !BSRR);
        m_rdata = m_err ? '0 : ix == 2 ? sy : ix < 6 ? rf[ix] : '0;
        if (PWRITE && !m_err) begin
          if (ix == 0 || ix == 1 || ix == 3 || ix == 4) rf[ix] = wd;
          if (ix == 5) clr_m = wd;
          if (ix == 6) rf[1] = (rf[1] & ~((PWDATA >> 16) & M)) | wd;
        end
      end else begin
        m_rdy = 0; m_err = 0;
      end
      rf[5] = (isr_o & ~clr_m) | set_m;
      for (int k = S; k > 0; k--) h[k] = h[k-1];
      h[0] = gpio_i;
    end
  end
  always @(negedge PCLK) begin
    chk("pready", PREADY, m_rdy);
    chk("pslverr", PSLVERR, m_err);
    chk("irq", irq, m_irq);
    chk("gpio_o", gpio_o, rf[1]);
    chk("gpio_oe", gpio_oe, rf[0]);
    if (m_rdy && m_rd) chk("prdata", PRDATA, m_rdata);
  end
  task automatic apb(input logic wr, input logic [4:0] a, input logic [31:0] d,
                     output logic [31:0] rdata, output logic err);
    int n;
    @(negedge PCLK);
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1;
    chk("rdy_acc1", PREADY, 0);
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!PREADY && n < 4);
    chk("rdy_acc2", PREADY, 1);
    chk("acc_len", 32'(n), 1);
    rdata = PRDATA; err = PSLVERR;
    PSEL = 0; PENABLE = 0;
  endtask
  initial begin
    repeat (3) @(negedge PCLK);
    chk("rst_o", gpio_o, 0);
    chk("rst_oe", gpio_oe, 0);
    chk("rst_irq", irq, 0);
    chk("rst_prdata", PRDATA, 0);
    PRESETn = 1;
    apb(1, 5'h00, 32'hFF, rd, er);
    apb(1, 5'h04, 32'hA5, rd, er);
    chk("oe_ff", gpio_oe, 32'hFF);
    chk("o_a5", gpio_o, 32'hA5);
    gpio_i = 8'h3C;
    repeat (3) @(negedge PCLK);
    apb(0, 5'h08, 0, rd, er);
    chk("idr", rd, 32'h3C);
    chk("idr_err", er, 0);
    apb(1, 5'h0C, 32'h01, rd, er);
    apb(1, 5'h10, 32'h01, rd, er);
    @(negedge PCLK);
    gpio_i[0] = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("irq_early", irq, 0);
    @(negedge PCLK);
    chk("irq_rise", irq, 1);
    apb(0, 5'h14, 0, rd, er);
    chk("isr_rise", rd, 32'h01);
    apb(1, 5'h14, 32'h01, rd, er);
    apb(0, 5'h14, 0, rd, er);
    chk("isr_w1c", rd, 0);
    chk("irq_w1c", irq, 0);
    apb(1, 5'h0C, 32'h02, rd, er);
    apb(1, 5'h10, 32'h00, rd, er);
    @(negedge PCLK);
    gpio_i[1] = 1'b1;
    repeat (5) @(negedge PCLK);
    gpio_i[2:1] = 2'b00;
    repeat (5) @(negedge PCLK);
    apb(0, 5'h14, 0, rd, er);
    chk("isr_fall", rd, 32'h02);
    chk("irq_fall", irq, 1);
    gpio_i[1] = 1'b1;
    repeat (5) @(negedge PCLK);
    @(negedge PCLK);
    gpio_i[1] = 1'b0;
    apb(1, 5'h14, 32'h02, rd, er);
    chk("irq_collide", irq, 1);
    apb(0, 5'h14, 0, rd, er);
    chk("isr_collide", rd, 32'h02);
    apb(1, 5'h1C, 32'hFFFF_FFFF, rd, er);
    chk("unm_wr_err", er, 1);
    apb(0, 5'h1C, 0, rd, er);
    chk("unm_rd_err", er, 1);
    chk("unm_rd_data", rd, 0);
    apb(0, 5'h00, 0, rd, er);
    chk("unm_mode", rd, 32'hFF);
    apb(0, 5'h04, 0, rd, er);
    chk("unm_odr", rd, 32'hA5);
    apb(1, 5'h04, 32'h0F, rd, er);
    apb(1, 5'h18, 32'h0003_0030, rd, er);
    chk("bsrr_err", er, !BSRR);
    chk("bsrr_odr", gpio_o, BSRR ? 32'h3C : 32'h0F);
    apb(1, 5'h18, 32'h0001_0001, rd, er);
    chk("bsrr_setwins", gpio_o, BSRR ? 32'h3D : 32'h0F);
    apb(0, 5'h18, 0, rd, er);
    chk("bsrr_rd", rd, 0);
    chk("bsrr_rd_err", er, !BSRR);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(2) == 0) begin
        @(negedge PCLK);
        gpio_i = W'($urandom);
      end
      repeat ($urandom_range(2)) @(negedge PCLK);
      apb(1'($urandom_range(1)), 5'($urandom_range(7) << 2), $urandom, rd, er);
    end
    repeat (4) @(negedge PCLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
